// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and constants for the HEX display scheduler.
package hex_display_scheduler_pkg;

    localparam int unsigned DIGIT_IDX_W = 3;
    localparam int unsigned HEX_VAL_W   = 4;
    localparam int unsigned SEG_W       = 7;

    // Active-low pattern with every segment dark.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SCAN    = 1'b0,
        REFRESH = 1'b1
    } state_e;

endpackage : hex_display_scheduler_pkg

// File: rtl/hex_display_scheduler_if.sv
// Digit write port: game logic (master) pushes per-digit values to the scheduler (slave).
interface hex_display_scheduler_if;
    import hex_display_scheduler_pkg::*;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [DIGIT_IDX_W-1:0] wr_digit;
    logic [HEX_VAL_W-1:0]   wr_value;
    logic                   wr_blank;

    modport master (
        output wr_valid,
        output wr_digit,
        output wr_value,
        output wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_digit,
        input  wr_value,
        input  wr_blank,
        output wr_ready
    );

endinterface : hex_display_scheduler_if

// File: rtl/hex_display_scheduler_seven_segment.sv
// Combinational 4-bit hex to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
module seven_segment
    import hex_display_scheduler_pkg::*;
(
    input  logic [HEX_VAL_W-1:0] value,
    output logic [SEG_W-1:0]     seg_c
);

    // Glyph lookup; lower-case b and d keep them distinct from 8 and 0.
    always_comb begin
        seg_c = SEG_BLANK;
        unique case (value)
            4'h0: seg_c = 7'b1000000;
            4'h1: seg_c = 7'b1111001;
            4'h2: seg_c = 7'b0100100;
            4'h3: seg_c = 7'b0110000;
            4'h4: seg_c = 7'b0011001;
            4'h5: seg_c = 7'b0010010;
            4'h6: seg_c = 7'b0000010;
            4'h7: seg_c = 7'b1111000;
            4'h8: seg_c = 7'b0000000;
            4'h9: seg_c = 7'b0011000;
            4'hA: seg_c = 7'b0001000;
            4'hB: seg_c = 7'b0000011;
            4'hC: seg_c = 7'b1000110;
            4'hD: seg_c = 7'b0100001;
            4'hE: seg_c = 7'b0000110;
            4'hF: seg_c = 7'b0001110;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule : seven_segment

// File: rtl/hex_display_scheduler.sv
// Scans a digit register file through one shared decoder into registered HEX outputs,
// with per-digit blanking, global clear and a free-running blink phase.
module hex_display_scheduler
    import hex_display_scheduler_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                        clk,
    input  logic                        rst,
    hex_display_scheduler_if.slave      wr,
    input  logic                        clr,
    input  logic [NUM_DIGITS-1:0]       blink_en,
    output logic [SEG_W*NUM_DIGITS-1:0] hex_out
);

    localparam int unsigned BLINK_CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_DIV - 1);
    localparam logic [DIGIT_IDX_W-1:0] PTR_LAST   = DIGIT_IDX_W'(NUM_DIGITS - 1);

    state_e                 state_q, state_d;
    logic [DIGIT_IDX_W-1:0] ptr_q, ptr_d;
    logic [HEX_VAL_W-1:0]   val_q [NUM_DIGITS];
    logic [HEX_VAL_W-1:0]   val_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  blank_q, blank_d;
    logic [SEG_W-1:0]       seg_q [NUM_DIGITS];
    logic [SEG_W-1:0]       seg_d [NUM_DIGITS];
    logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic                   phase_q, phase_d;

    logic                   wr_ready_c;
    logic                   wr_accept_c;
    logic                   wr_in_range_c;
    logic                   blink_wrap_c;
    logic [DIGIT_IDX_W-1:0] ptr_next_c;
    logic [SEG_W-1:0]       dec_seg_c;
    logic [SEG_W-1:0]       seg_new_c;

    // Single shared decoder always looks at the digit under the scan pointer.
    seven_segment u_seven_segment (
        .value (val_q[ptr_q]),
        .seg_c (dec_seg_c)
    );

    // Writes are taken only while scanning and never while reset is held.
    assign wr_ready_c  = (state_q == SCAN) && !rst;
    assign wr.wr_ready = wr_ready_c;
    assign wr_accept_c = wr.wr_valid && wr_ready_c;

    // Indices past the last driven digit are swallowed without touching the register file.
    if (NUM_DIGITS >= (2 ** DIGIT_IDX_W)) begin : g_idx_full
        assign wr_in_range_c = 1'b1;
    end else begin : g_idx_part
        assign wr_in_range_c = (wr.wr_digit < DIGIT_IDX_W'(NUM_DIGITS));
    end

    assign ptr_next_c   = (ptr_q == PTR_LAST) ? '0 : ptr_q + DIGIT_IDX_W'(1);
    assign blink_wrap_c = (blink_cnt_q == BLINK_LAST);

    // Blanked or blink-dark digits show all segments off; otherwise the decoded glyph.
    assign seg_new_c = (blank_q[ptr_q] || (blink_en[ptr_q] && phase_q)) ? SEG_BLANK : dec_seg_c;

    // Next-state: scan latch, write capture, clear override and blink timebase.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        val_d       = val_q;
        blank_d     = blank_q;
        seg_d       = seg_q;
        blink_cnt_d = blink_wrap_c ? '0 : blink_cnt_q + BLINK_CNT_W'(1);
        phase_d     = phase_q ^ blink_wrap_c;

        // Every edge re-latches the digit under the pointer, in either state.
        seg_d[ptr_q] = seg_new_c;

        unique case (state_q)
            SCAN: begin
                ptr_d = ptr_next_c;
                if (wr_accept_c) begin
                    state_d = REFRESH;
                    if (wr_in_range_c) begin
                        ptr_d = wr.wr_digit;
                        if (!clr) begin
                            val_d[wr.wr_digit]   = wr.wr_value;
                            blank_d[wr.wr_digit] = wr.wr_blank;
                        end
                    end else begin
                        ptr_d = '0;
                    end
                end
            end
            REFRESH: begin
                ptr_d   = ptr_next_c;
                state_d = SCAN;
            end
            default: begin
                state_d = SCAN;
                ptr_d   = '0;
            end
        endcase

        // Clear blanks everything and wins over a same-cycle write.
        if (clr) begin
            blank_d = '1;
        end
    end

    // State register; reset drops everything to dark/idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            ptr_q       <= '0;
            val_q       <= '{default: '0};
            blank_q     <= '1;
            seg_q       <= '{default: SEG_BLANK};
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            val_q       <= val_d;
            blank_q     <= blank_d;
            seg_q       <= seg_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Digit d occupies hex_out[7d+6:7d] straight from its segment register.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex_out
        assign hex_out[g*SEG_W +: SEG_W] = seg_q[g];
    end

endmodule : hex_display_scheduler
